// File: rtl/change_dispense_ctrl_pkg.sv
// change_dispense_ctrl_pkg: shared state encoding, coin values and hopper select codes
package change_dispense_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_WAIT, S_FINISH} state_t;
  localparam logic [2:0] HALF_VAL = 3'd1;
  localparam logic [2:0] ONE_VAL  = 3'd2;
  localparam logic SEL_HALF = 1'b0;
  localparam logic SEL_ONE  = 1'b1;
endpackage

// File: rtl/change_dispense_ctrl_hopper_stock.sv
// hopper_stock: one hopper's coin count with saturating refill/decrement and a fault flag
// Ports: clk/rst (async active-low), dec (coin confirmed), refill + refill_cnt (coins added),
//        fault_set (hopper timed out), stock (current count), fault (hopper disabled until refilled)
module hopper_stock #(
  parameter int STOCK_W    = 6,
  parameter int STOCK_INIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_cnt,
  input  logic               fault_set,
  output logic [STOCK_W-1:0] stock,
  output logic               fault
);
  logic [STOCK_W:0] w_sum;
  // one extra bit catches refill overflow; dec only happens with stock > 0 so no underflow
  assign w_sum = {1'b0, stock} - {{STOCK_W{1'b0}}, dec} + (refill ? {1'b0, refill_cnt} : '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stock <= STOCK_W'(STOCK_INIT);
      fault <= 1'b0;
    end else begin
      stock <= w_sum[STOCK_W] ? '1 : w_sum[STOCK_W-1:0];
      fault <= !refill && (fault || fault_set);
    end
endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: greedy one-coin-at-a-time change dispenser for half and one yuan hoppers
// Ports: clk, rst (async active-low); req/amount (change request in half-yuan units);
//        refill/refill_sel/refill_cnt (stock top-up); sense_half/sense_one (coin-passed pulses);
//        eject_half/eject_one (motor drives); busy/done/err/remaining (status to seller);
//        stock_half/stock_one/low_stock (inventory)
module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int PULSE_CYC  = 4,
  parameter int TIMEOUT    = 64,
  parameter int STOCK_W    = 6,
  parameter int STOCK_INIT = 20,
  parameter int LOW_TH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [2:0]         amount,
  input  logic               refill,
  input  logic               refill_sel,
  input  logic [STOCK_W-1:0] refill_cnt,
  input  logic               sense_half,
  input  logic               sense_one,
  output logic               eject_half,
  output logic               eject_one,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         remaining,
  output logic [STOCK_W-1:0] stock_half,
  output logic [STOCK_W-1:0] stock_one,
  output logic               low_stock
);
  localparam int CW = $clog2(TIMEOUT + PULSE_CYC);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_rem;
  logic          r_sel, r_conf, r_err, r_done;
  logic          w_sense, w_can_one, w_can_half, w_accept, w_confirm, w_tmo;
  logic          w_fault_half, w_fault_one;
  assign w_sense    = r_sel ? sense_one : sense_half;
  assign w_can_one  = r_rem >= ONE_VAL && stock_one != '0 && !w_fault_one;
  assign w_can_half = stock_half != '0 && !w_fault_half;
  assign w_accept   = r_state == S_IDLE && req && amount != 3'd0;
  always_comb begin
    w_next    = r_state;
    w_confirm = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_IDLE:   w_next = w_accept ? S_SELECT : S_IDLE;
      S_SELECT: w_next = (r_rem == 3'd0 || !(w_can_one || w_can_half)) ? S_FINISH : S_EJECT;
      S_EJECT: if (r_cnt == CW'(PULSE_CYC - 1)) begin
        // an early sense was latched in r_conf; the pulse always runs to full length
        w_confirm = r_conf || w_sense;
        w_next    = w_confirm ? S_SELECT : S_WAIT;
      end
      S_WAIT: begin
        w_confirm = w_sense;
        w_tmo     = !w_sense && r_cnt == CW'(TIMEOUT - 1);
        w_next    = (w_confirm || w_tmo) ? S_SELECT : S_WAIT;
      end
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= 3'd0;
      r_sel   <= SEL_HALF;
      r_conf  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && (r_state == S_EJECT || r_state == S_WAIT)) ? r_cnt + CW'(1) : '0;
      r_conf  <= r_state == S_EJECT && (r_conf || w_sense);
      r_sel   <= r_state == S_SELECT ? (w_can_one ? SEL_ONE : SEL_HALF) : r_sel;
      r_rem   <= w_accept ? amount : w_confirm ? r_rem - (r_sel ? ONE_VAL : HALF_VAL) : r_rem;
      r_err   <= w_accept ? 1'b0 :
                 (r_state == S_SELECT && r_rem != 3'd0 && !(w_can_one || w_can_half)) ? 1'b1 : r_err;
      // registered so done lands one cycle after FINISH, and one cycle after a zero-amount req
      r_done  <= r_state == S_FINISH || (r_state == S_IDLE && req && amount == 3'd0);
    end
  hopper_stock #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_half (
    .clk(clk), .rst(rst),
    .dec(w_confirm && r_sel == SEL_HALF),
    .refill(refill && refill_sel == SEL_HALF),
    .refill_cnt(refill_cnt),
    .fault_set(w_tmo && r_sel == SEL_HALF),
    .stock(stock_half), .fault(w_fault_half)
  );
  hopper_stock #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_one (
    .clk(clk), .rst(rst),
    .dec(w_confirm && r_sel == SEL_ONE),
    .refill(refill && refill_sel == SEL_ONE),
    .refill_cnt(refill_cnt),
    .fault_set(w_tmo && r_sel == SEL_ONE),
    .stock(stock_one), .fault(w_fault_one)
  );
  assign eject_half = r_state == S_EJECT && r_sel == SEL_HALF;
  assign eject_one  = r_state == S_EJECT && r_sel == SEL_ONE;
  assign busy       = r_state == S_SELECT || r_state == S_EJECT || r_state == S_WAIT;
  assign done       = r_done;
  assign err        = r_err;
  assign remaining  = r_rem;
  assign low_stock  = stock_half < STOCK_W'(LOW_TH) || stock_one < STOCK_W'(LOW_TH);
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb_change_dispense_ctrl: directed table, hand sequences and random runs against a greedy change model
module tb_change_dispense_ctrl;
  localparam int PULSE_CYC = 4;
  logic clk = 0, rst = 0, req = 0, tgt = 0;
  logic [2:0] amount = 0;
  logic refill = 0, refill_sel = 0, sense_half = 0, sense_one = 0;
  logic [5:0] refill_cnt = 0;
  logic eh0, eo0, busy0, done0, err0, low0, eh1, eo1, busy1, done1, err1, low1;
  logic [2:0] rem0, rem1;
  logic [5:0] sh0, so0, sh1, so1;
  logic x_eh, x_eo, x_busy, x_done, x_err, x_low;
  logic [2:0] x_rem;
  logic [5:0] x_sh, x_so;
  int total = 0, bad = 0;
  int m_sh, m_so;
  bit m_fh, m_fo;

  always #5 clk = ~clk;

  change_dispense_ctrl dut (
    .clk(clk), .rst(rst), .req(req & !tgt), .amount(amount), .refill(refill & !tgt),
    .refill_sel(refill_sel), .refill_cnt(refill_cnt), .sense_half(sense_half), .sense_one(sense_one),
    .eject_half(eh0), .eject_one(eo0), .busy(busy0), .done(done0), .err(err0), .remaining(rem0),
    .stock_half(sh0), .stock_one(so0), .low_stock(low0));

  change_dispense_ctrl #(.STOCK_INIT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req & tgt), .amount(amount), .refill(refill & tgt),
    .refill_sel(refill_sel), .refill_cnt(refill_cnt), .sense_half(sense_half), .sense_one(sense_one),
    .eject_half(eh1), .eject_one(eo1), .busy(busy1), .done(done1), .err(err1), .remaining(rem1),
    .stock_half(sh1), .stock_one(so1), .low_stock(low1));

  assign x_eh = tgt ? eh1 : eh0;
  assign x_eo = tgt ? eo1 : eo0;
  assign x_busy = tgt ? busy1 : busy0;
  assign x_done = tgt ? done1 : done0;
  assign x_err = tgt ? err1 : err0;
  assign x_low = tgt ? low1 : low0;
  assign x_rem = tgt ? rem1 : rem0;
  assign x_sh = tgt ? sh1 : sh0;
  assign x_so = tgt ? so1 : so0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one request, answers each eject with a sense pulse (per mask bit) and records eject order.
  task automatic run_txn(input logic [2:0] amt, input logic [15:0] mask, input bit rnd, input bit rfs,
                         input int xr, output logic [15:0] seq, output int n);
    bit prev, cur, pend, got, last;
    int cd, width;
    seq = '0; n = 0; prev = 0; pend = 0; got = 0; last = 0; cd = 0; width = 0;
    @(negedge clk); req = 1; amount = amt;
    @(negedge clk); req = 0;
    for (int c = 0; c < 3000; c++) begin
      sense_half = 0; sense_one = 0; refill = 0;
      if (x_done) begin got = 1; break; end
      req = (c == xr);
      if (c == xr) amount = 3'd7;
      cur = x_eh | x_eo;
      if (x_eh && x_eo) chk("both_eject", 1, 0);
      if (cur && !prev) begin
        if (n < 16) seq[n] = x_eo;
        last = x_eo;
        if (mask[n % 16]) begin pend = 1; cd = rnd ? int'($urandom_range(0, 9)) : 3; end
        n++;
        width = 0;
      end
      if (cur) width++;
      if (!cur && prev) chk("pulse_width", width, PULSE_CYC);
      if (pend && cd == 0) begin
        if (last) sense_one = 1; else sense_half = 1;
        pend = 0;
        if (rfs) begin refill = 1; refill_sel = last; refill_cnt = '1; end
      end else if (pend) cd--;
      else if (rnd && n > 0 && $urandom_range(0, 7) == 0) begin
        if (last) sense_half = 1; else sense_one = 1;
      end
      prev = cur;
      @(negedge clk);
    end
    sense_half = 0; sense_one = 0; refill = 0; req = 0;
    chk("done_seen", got, 1);
  endtask

  // Greedy change model: plain arithmetic over stocks, faults and the coins the bench chose to confirm.
  task automatic model_txn(input int amt, input logic [15:0] mask, output logic [15:0] seq,
                           output int n, output int rem, output bit e);
    int c;
    seq = '0; n = 0; rem = amt; e = 0;
    while (rem > 0) begin
      if (rem >= 2 && m_so > 0 && !m_fo) c = 1;
      else if (m_sh > 0 && !m_fh) c = 0;
      else begin e = 1; break; end
      seq[n] = c[0];
      if (mask[n]) begin
        if (c == 1) begin rem -= 2; m_so--; end else begin rem -= 1; m_sh--; end
      end else if (c == 1) m_fo = 1;
      else m_fh = 1;
      n++;
    end
  endtask

  typedef struct {
    bit tgt; bit rf; bit rf_sel; logic [5:0] rf_cnt; logic [2:0] amt; logic [15:0] mask; bit rfs; int xr;
    logic [15:0] seq; int n; logic [2:0] rem; bit err; logic [5:0] sh; logic [5:0] so; bit low;
  } vec_t;
  vec_t vt[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq, eseq, mask;
    int n, en, erem, amt, xr;
    bit eerr;
    vt[0] = '{0, 0, 0, 0, 5, 16'hFFFF, 0, -1, 16'b011,   3, 0, 0, 19, 18, 0};
    vt[1] = '{0, 0, 0, 0, 4, 16'hFFFE, 0, -1, 16'b00001, 5, 0, 0, 15, 18, 0};
    vt[2] = '{0, 1, 1, 0, 7, 16'hFFFF, 0, -1, 16'b0111,  4, 0, 0, 14, 15, 0};
    vt[3] = '{0, 0, 0, 0, 1, 16'hFFFF, 0,  2, 16'b0,     1, 0, 0, 13, 15, 0};
    vt[4] = '{0, 1, 0, 10, 6, 16'hFFFF, 0, -1, 16'b111,  3, 0, 0, 23, 12, 0};
    vt[5] = '{0, 0, 0, 0, 1, 16'hFFFF, 1, -1, 16'b0,     1, 0, 0, 63, 12, 0};
    vt[6] = '{1, 0, 0, 0, 4, 16'hFFFF, 0, -1, 16'b01,    2, 1, 1, 0, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst_stock_half", sh0, 20);
    chk("rst_stock_one", so0, 20);
    chk("rst_outs", {eh0, eo0, busy0, done0, err0, low0}, 0);
    chk("rst_remaining", rem0, 0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_outs", {eh0, eo0, busy0, done0, err0, low0}, 0);

    for (int i = 0; i < 7; i++) begin
      tgt = vt[i].tgt;
      if (vt[i].rf) begin
        @(negedge clk); refill = 1; refill_sel = vt[i].rf_sel; refill_cnt = vt[i].rf_cnt;
        @(negedge clk); refill = 0;
      end
      run_txn(vt[i].amt, vt[i].mask, 0, vt[i].rfs, vt[i].xr, seq, n);
      chk($sformatf("v%0d_seq", i), seq, vt[i].seq);
      chk($sformatf("v%0d_coins", i), n, vt[i].n);
      chk($sformatf("v%0d_rem", i), x_rem, vt[i].rem);
      chk($sformatf("v%0d_err", i), x_err, vt[i].err);
      chk($sformatf("v%0d_stock_half", i), x_sh, vt[i].sh);
      chk($sformatf("v%0d_stock_one", i), x_so, vt[i].so);
      chk($sformatf("v%0d_low", i), x_low, vt[i].low);
      chk($sformatf("v%0d_busy", i), x_busy, 0);
    end
    tgt = 0;

    @(negedge clk); req = 1; amount = 0;
    @(negedge clk); req = 0;
    chk("zero_done", done0, 1);
    chk("zero_busy", busy0, 0);
    chk("zero_eject", {eh0, eo0}, 0);
    @(negedge clk);
    chk("zero_done_off", done0, 0);
    chk("zero_busy_off", busy0, 0);

    @(negedge clk); req = 1; amount = 2;
    @(negedge clk); req = 0;
    @(negedge clk);
    chk("pre_rst_eject_one", eo0, 1);
    rst = 0;
    #1;
    chk("rst_mid_eject", {eh0, eo0}, 0);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_stock_half", sh0, 20);
    chk("rst_mid_stock_one", so0, 20);
    chk("rst_mid_remaining", rem0, 0);
    @(negedge clk); rst = 1;
    m_sh = 20; m_so = 20; m_fh = 0; m_fo = 0;

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); refill = 1; refill_sel = 1'($urandom_range(0, 1)); refill_cnt = 6'($urandom_range(0, 63));
        if (refill_sel) begin m_so = (m_so + refill_cnt > 63) ? 63 : m_so + refill_cnt; m_fo = 0; end
        else begin m_sh = (m_sh + refill_cnt > 63) ? 63 : m_sh + refill_cnt; m_fh = 0; end
        @(negedge clk); refill = 0;
      end
      amt = $urandom_range(1, 7);
      for (int k = 0; k < 16; k++) mask[k] = ($urandom_range(0, 7) != 0);
      xr = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
      model_txn(amt, mask, eseq, en, erem, eerr);
      run_txn(3'(amt), mask, 1, 0, xr, seq, n);
      chk($sformatf("r%0d_seq", t), seq, eseq);
      chk($sformatf("r%0d_coins", t), n, en);
      chk($sformatf("r%0d_rem", t), rem0, erem);
      chk($sformatf("r%0d_err", t), err0, eerr);
      chk($sformatf("r%0d_stock_half", t), sh0, m_sh);
      chk($sformatf("r%0d_stock_one", t), so0, m_so);
      chk($sformatf("r%0d_low", t), low0, (m_sh < 4 || m_so < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequencer for the vending machine's two coin hoppers: 0.5-yuan ("half") and 1-yuan ("one").
- Accepts a change request from the seller FSM, expressed in 0.5-yuan units.
- Dispenses the change greedily, one coin at a time: pulses the hopper motor, then waits for the coin-sense confirmation.
- Maintains per-hopper stock counts and fault flags, and reports done/err back to the seller.

Parameters:
- PULSE_CYC, 4: cycles eject_* is held high per coin.
- TIMEOUT, 64: cycles in WAIT without a sense pulse before declaring a hopper fault.
- STOCK_W, 6: stock counter width (max 63).
- STOCK_INIT, 20: stock value of each hopper after reset.
- LOW_TH, 4: low_stock asserts when either stock < LOW_TH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  one-cycle change request
- amount  in  3  change owed, in 0.5-yuan units (0..7); sampled with req
- refill  in  1  one-cycle refill strobe
- refill_sel  in  1  0 = half hopper, 1 = one hopper
- refill_cnt  in  STOCK_W  coins added by refill
- sense_half  in  1  synchronous one-cycle coin-passed pulse, half hopper
- sense_one  in  1  same, one hopper
- eject_half  out  1  half hopper motor drive
- eject_one  out  1  one hopper motor drive
- busy  out  1  dispense in progress
- done  out  1  one-cycle completion pulse
- err  out  1  change could not be completed; sticky until next accepted req
- remaining  out  3  units still owed
- stock_half  out  STOCK_W  half hopper count
- stock_one  out  STOCK_W  one hopper count
- low_stock  out  1  either stock < LOW_TH

Behaviour:
- Reset (rst=0, async):
  - state IDLE; all 1-bit outputs 0; remaining 0.
  - stocks = STOCK_INIT; both fault flags cleared.
- FSM states: IDLE, SELECT, EJECT, WAIT, FINISH.
- IDLE:
  - req with amount!=0: latch remaining=amount, clear err, busy=1, go to SELECT.
  - req with amount==0: done=1 the next cycle, stay IDLE, no eject.
- SELECT (1 cycle):
  - remaining==0: go to FINISH.
  - remaining>=2, stock_one>0 and !fault_one: pick one.
  - else stock_half>0 and !fault_half: pick half.
  - else set err=1, go to FINISH; remaining keeps the unpaid value.
- EJECT: drive the selected eject_* high for exactly PULSE_CYC cycles, then go to WAIT. Never drive both eject_* high.
- WAIT:
  - Timer counts from 0. A sense pulse on the selected hopper during EJECT or WAIT counts as the confirmation.
  - On confirmation: remaining -= coin value (1 or 2), selected stock -= 1, go to SELECT. If the pulse arrives during EJECT, finish the pulse first, then go straight to SELECT.
  - Timer reaches TIMEOUT: set the fault flag of that hopper, leave stock and remaining unchanged, go to SELECT (which may fall back to the other hopper).
  - A sense pulse on the non-selected hopper is ignored.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Latency (req at cycle 0):
  - SELECT in cycle 1; eject_* high in cycles 2..PULSE_CYC+1.
  - Best case amount=2 with an immediate sense: done in cycle PULSE_CYC+4.
- req while busy: ignored; not queued.
- Refill (accepted in any state):
  - stock_sel += refill_cnt, saturating at 2^STOCK_W-1; clears that hopper's fault flag.
  - Refill and confirmed decrement on the same hopper in the same cycle: new = stock - 1 + refill_cnt, saturating.
- Stock never decrements below 0; SELECT guarantees stock>0 before ejecting.
- low_stock is combinational from the stock registers.
- Reset mid-dispense: eject drops immediately; the partial change is lost; the seller re-requests.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Coin value constants HALF_VAL=1, ONE_VAL=2.
  - Hopper select encoding (0 = half, 1 = one).
- One natural sub-module: hopper_stock, instantiated twice.
  - Contents: stock counter with saturating refill/decrement and the fault flag set/clear.
  - Ports: clk, rst, dec, refill, refill_cnt, fault_set, stock, fault.

Test Plan:
- Reset: hold rst low for 2 cycles → stock_half=stock_one=20, all outputs 0, low_stock=0.
- req amount=5, each sense pulse 3 cycles after eject rises → eject order one, one, half; done pulse; remaining=0, err=0, stock_one=18, stock_half=19.
- req amount=4, sense_one never pulses → one ejected, fault after 64 WAIT cycles, then four half ejects; done, err=0, stock_one=20, stock_half=16; refill_sel=1 with refill_cnt=0 clears the fault.
- STOCK_INIT=1, req amount=4 → one (rem 2), half (rem 1), then err=1, done pulse, remaining=1, both stocks 0, low_stock=1.
- req amount=0 → done exactly one cycle later, busy stays 0, no eject; a second req while busy during another dispense is ignored.
- refill_sel=0, refill_cnt=63 while a half coin is confirmed in the same cycle → stock_half saturates at 63; rst asserted during EJECT → eject_* drops immediately, busy=0, stocks=20.
